// File: rtl/ex_wb_stage.sv
// Execute-to-writeback boundary: 2-entry skid-buffered result register,
// architectural flag register and registered branch resolution.
module ex_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [2:0]         in_flag,
  input  logic               in_flag_we,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wr_en,
  input  logic [2:0]         in_br_type,
  input  logic [DATA_W-1:0]  in_br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wr_en,
  output logic [2:0]         flag_reg,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  branch_target
);

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_result;
  logic [RADDR_W-1:0] r_out_rd;
  logic               r_out_wr_en;
  logic               r_skid_valid;
  logic [DATA_W-1:0]  r_skid_result;
  logic [RADDR_W-1:0] r_skid_rd;
  logic               r_skid_wr_en;
  logic [2:0]         r_flag;
  logic               r_br_taken;
  logic [DATA_W-1:0]  r_br_target;

  logic w_accept;
  logic w_main_free;
  logic w_taken;

  // in_ready is a pure function of state, so it never sees out_ready combinationally.
  assign in_ready    = ~r_skid_valid;
  assign w_accept    = in_valid & in_ready;
  assign w_main_free = ~r_out_valid | out_ready;

  // Carry branches look at the stored flags, not the beat's own flags.
  always_comb begin
    w_taken = 1'b0;
    case (in_br_type)
      3'b001, 3'b111: w_taken = 1'b1;
      3'b010:         w_taken = in_flag[2];
      3'b011:         w_taken = in_flag[1];
      3'b100:         w_taken = ~in_flag[1];
      3'b101:         w_taken = r_flag[0];
      3'b110:         w_taken = ~r_flag[0];
      default:        w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_rd      <= '0;
      r_out_wr_en   <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_rd     <= '0;
      r_skid_wr_en  <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_result <= r_skid_result;
        r_out_rd     <= r_skid_rd;
        r_out_wr_en  <= r_skid_wr_en;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_result <= in_result;
          r_skid_rd     <= in_rd;
          r_skid_wr_en  <= in_wr_en;
        end
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_result <= in_result;
          r_out_rd     <= in_rd;
          r_out_wr_en  <= in_wr_en;
        end
      end
    end else if (w_accept) begin
      r_skid_valid  <= 1'b1;
      r_skid_result <= in_result;
      r_skid_rd     <= in_rd;
      r_skid_wr_en  <= in_wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag      <= 3'b000;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_br_taken <= w_accept & w_taken;
      if (w_accept & w_taken) r_br_target <= in_br_target;
      if (w_accept & in_flag_we) r_flag <= in_flag;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_rd        = r_out_rd;
  assign out_wr_en     = r_out_wr_en;
  assign flag_reg      = r_flag;
  assign branch_taken  = r_br_taken;
  assign branch_target = r_br_target;

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Registered execute-to-writeback boundary, directly downstream of the 32-bit ALU.
- Captures ALU result, 3-bit flag vector and destination info behind a valid/ready handshake with a 2-entry skid buffer.
- Maintains the architectural flag register and resolves conditional branches from ALU flags and stored carry.
- Issues a one-cycle branch_taken pulse with target to the fetch stage.

Parameters:
- DATA_W, 32, datapath width of result and branch target.
- RADDR_W, 5, destination register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_result  input  DATA_W  ALU result.
- in_flag  input  3  ALU flags [2]=sign(a), [1]=zero(a), [0]=carry.
- in_flag_we  input  1  update flag register on acceptance.
- in_rd  input  RADDR_W  destination register.
- in_wr_en  input  1  register-file write request.
- in_br_type  input  3  branch type: 000 none, 001 b, 010 bltz, 011 bz, 100 bnz, 101 bcy, 110 bncy, 111 bl.
- in_br_target  input  DATA_W  branch target address.
- out_valid  output  1  writeback beat valid.
- out_ready  input  1  writeback consumer ready.
- out_result  output  DATA_W  registered result.
- out_rd  output  RADDR_W  registered destination.
- out_wr_en  output  1  registered write enable.
- flag_reg  output  3  architectural flags {sign,zero,carry}.
- branch_taken  output  1  one-cycle taken pulse.
- branch_target  output  DATA_W  target, valid while branch_taken=1.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - out_valid=0, out_result=0, out_rd=0, out_wr_en=0.
  - flag_reg=000, branch_taken=0, branch_target=0.
  - Skid entry empty; in_ready=1 on the first cycle after reset.
  - Assertion mid-operation drops all buffered beats; nothing is replayed.
- Acceptance: in_valid & in_ready at a rising edge. in_ready is registered and equals !skid_full.
- Buffering, two entries (main = output register, skid):
  - Main empty or draining (out_valid=0 or out_ready=1): the accepted beat loads main, with 1-cycle latency to out_*.
  - Main stalled (out_valid=1, out_ready=0): the accepted beat loads skid; in_ready drops the next cycle.
  - Main drains while skid is full: skid moves to main and in_ready returns to 1 the next cycle.
  - Acceptance and a skid move in the same cycle: skid→main and new→skid; ordering is strictly FIFO.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Flag register: on acceptance with in_flag_we=1, flag_reg <= in_flag at that edge. With in_flag_we=0 it holds.
- Branch resolution, evaluated only on the acceptance cycle:
  - 001 b and 111 bl: always taken.
  - 010 bltz: taken iff in_flag[2]=1.
  - 011 bz: taken iff in_flag[1]=1.
  - 100 bnz: taken iff in_flag[1]=0.
  - 101 bcy: taken iff flag_reg[0]=1.
  - 110 bncy: taken iff flag_reg[0]=0.
  - 000 none: never taken.
  - bcy/bncy use flag_reg as it stood before that edge, even if the same beat has in_flag_we=1.
- Branch output timing:
  - branch_taken is registered and asserts for exactly one cycle after the accepting edge.
  - branch_target is registered from in_br_target at the same edge and holds its last value otherwise.
  - Branch resolution does not depend on out_ready.
- Back-to-back taken branches accepted on consecutive cycles give consecutive pulses, each with its own target.
- Beats with in_wr_en=0 still flow through the buffer (out_valid=1, out_wr_en=0).
- No combinational path from in_* to out_*. in_ready has no combinational dependence on out_ready.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0, flag_reg=000. Release → in_ready=1 next cycle.
- Stream with out_ready=1: results 0x1,0x2,0x3 on consecutive cycles → out_result shows 0x1,0x2,0x3 one cycle later each, out_valid continuous, in_ready stays 1.
- Backpressure:
  - Drop out_ready while sending 0xA,0xB,0xC → 0xA holds on the output, 0xB goes to skid, in_ready=0, 0xC is not accepted.
  - Raise out_ready → order is 0xA,0xB,0xC with none lost.
- Flag and carry branch:
  - Add beat with in_flag=001 and in_flag_we=1, then bcy to 0x40 → flag_reg=001 and branch_taken pulses once with target 0x40.
  - A same-beat bcy with in_flag_we=1 and in_flag=001 while flag_reg=000 → not taken.
- Zero/sign branches: bz with in_flag=010 → taken; bnz with same flags → not taken; bltz with in_flag=100 → taken; type 000 → no pulse.
- Async reset mid-stall (skid full, out_ready=0): assert rst_n → out_valid=0 immediately with no clk edge needed, buffers empty after release.
